mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
- Sits between the CPU datapath and the byte-addressed, big-endian MIPS data memory.
- Turns load/store requests into the memory-side port set: word address, `wr_en`, `read_en`, `byte_en`, `data_in`.
- Memory read data arrives one clock after `read_en` is sampled. The unit aligns it to the requested width and sign/zero-extends it.
- Catches misaligned accesses before any memory transaction and returns a single-cycle response to the CPU.

Parameters:
- `CHECK_ALIGN`, 1: 1 = misaligned halfword/word gives `resp_err` with no memory access. 0 = address low bits are forced to alignment and no error is raised.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cpu_valid`  in  1  request present
- `cpu_ready`  out  1  unit idle, request accepted when `cpu_valid` & `cpu_ready`
- `cpu_store`  in  1  1 = store, 0 = load (opcode bit 3)
- `cpu_op`  in  3  000 B, 001 H, 011 W, 100 BU, 101 HU (opcode[2:0])
- `cpu_addr`  in  32  byte address
- `cpu_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  32  extended load result (0 for stores and errors)
- `resp_err`  out  1  misaligned or illegal op
- `mem_address`  out  32  {addr[31:2], 2'b00}
- `mem_read_en`  out  1  memory read strobe
- `mem_wr_en`  out  1  memory write strobe
- `mem_byte_en`  out  4  `byte_en[i]` enables data bits [8i+7:8i]
- `mem_data_in`  out  32  write data to memory
- `mem_data_out`  in  32  memory read data, valid the cycle after `read_en` sampled

Behaviour:
- Reset (async, `rst_n`=0):
  - state IDLE.
  - `cpu_ready`=1.
  - `resp_valid`, `resp_err`, `mem_read_en`, `mem_wr_en` = 0.
  - `mem_byte_en`=0.
  - `mem_address`, `mem_data_in`, `resp_rdata` = 0.
  - Reset mid-operation drops the pending op: no response is issued and no further memory strobe is driven.
- Endianness (fixed): byte offset k = `addr[1:0]` maps to lane 3-k, i.e. bits [31-8k:24-8k].
- FSM states: IDLE, ISSUE, CAPTURE, RESP. All outputs are registered.
- IDLE:
  - `cpu_ready`=1.
  - On accept, illegal op (010, 110, 111, or store with op 100/101) or misalignment (H with `addr[0]`=1, W with `addr[1:0]`≠0, `CHECK_ALIGN`=1) goes straight to RESP with `resp_err`=1.
  - Any other accepted request goes to ISSUE.
  - `cpu_valid` while not IDLE is ignored; the CPU must hold it until `cpu_ready`.
- ISSUE, exactly one cycle:
  - Load: `mem_read_en`=1, `mem_byte_en`=1111, then CAPTURE.
  - Store: `mem_wr_en`=1, then RESP.
  - `mem_read_en` and `mem_wr_en` are never high together and never high outside ISSUE.
- Store lane generation:
  - SB: `mem_data_in`={4{`wdata[7:0]`}}, `mem_byte_en`=one-hot bit (3-k).
  - SH: `mem_data_in`={2{`wdata[15:0]`}}, `mem_byte_en` = `addr[1]` ? 0011 : 1100.
  - SW: `mem_data_in`=`wdata`, `mem_byte_en`=1111.
- CAPTURE: sample `mem_data_out`, extract and extend, then RESP.
  - B/BU: selected lane, sign/zero-extended.
  - H/HU: [31:16] if `addr[1]`=0, else [15:0], sign/zero-extended.
  - W: whole word.
- RESP: `resp_valid`=1 for exactly one cycle, with `resp_rdata`/`resp_err` stable; then IDLE with `cpu_ready`=1 on the next cycle.
- Latency, counted in cycles after the accept edge:
  - error: `resp_valid` in cycle 1.
  - store: `resp_valid` in cycle 2.
  - load: `resp_valid` in cycle 3.
- Back-to-back requests: next accept no earlier than the cycle after RESP.
- `resp_valid` has no backpressure.
- Request fields are latched at accept; later changes on `cpu_*` have no effect.

Test Plan (memory word at 0x00000100 = 0x8899AABB unless stated):
- LB 0x101 -> one `mem_read_en` pulse at `mem_address` 0x100, `resp_valid` 3 cycles after accept, `resp_rdata`=0xFFFFFF99, `resp_err`=0.
- LBU 0x103 -> 0x000000BB. LH 0x102 -> 0xFFFFAABB. LHU 0x100 -> 0x00008899. LW 0x100 -> 0x8899AABB.
- SB 0x102, `wdata` 0x12345678 -> one `mem_wr_en` pulse, `mem_byte_en`=0010, `mem_data_in`=0x78787878; following LW 0x100 returns 0x889978BB. SH 0x100 -> `mem_byte_en`=1100, data 0x56785678.
- LW 0x106 and SH 0x101 with `CHECK_ALIGN`=1 -> `resp_valid` 1 cycle after accept, `resp_err`=1, `resp_rdata`=0, no memory strobe. Illegal op 111 -> same.
- `rst_n` low during CAPTURE of an LW -> outputs return to reset values immediately, no `resp_valid`, `cpu_ready`=1 after release; next LBU 0x100 returns 0x00000088.
- Back-to-back SW 0x104 0xDEADBEEF then LW 0x104 with `cpu_valid` held high -> second accept in the cycle after the first `resp_valid`, LW returns 0xDEADBEEF; `cpu_ready`=0 throughout each op.

Source files
------------

// File: rtl/mips_load_store_unit.sv
// Load/store unit between the MIPS datapath and a big-endian, byte-addressed data memory.
// Handles lane steering, load extension and alignment checks; memory reads return one cycle after the strobe.
module mips_load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_store,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is accepted on a rising edge where cpu_valid && cpu_ready;
    // resp_valid is a single-cycle pulse with no backpressure.
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state;
    logic        req_store;
    logic [2:0]  req_op;
    logic [1:0]  req_off;

    logic        illegal_op;
    logic        misaligned;
    logic [1:0]  off_aligned;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign dbg_state = state;

    // Decode of the request currently on the cpu_* inputs, used only at accept.
    always_comb begin
        illegal_op  = 1'b0;
        misaligned  = 1'b0;
        off_aligned = cpu_addr[1:0];
        case (cpu_op)
            3'b000, 3'b001, 3'b011: illegal_op = 1'b0;
            3'b100, 3'b101:         illegal_op = cpu_store;
            default:                illegal_op = 1'b1;
        endcase
        if (cpu_op[1:0] == 2'b01) begin
            misaligned     = CHECK_ALIGN && cpu_addr[0];
            off_aligned[0] = 1'b0;
        end else if (cpu_op[1:0] == 2'b11) begin
            misaligned  = CHECK_ALIGN && (cpu_addr[1:0] != 2'b00);
            off_aligned = 2'b00;
        end
    end

    // Byte offset k lands in lane 3-k (big-endian).
    always_comb begin
        store_be   = 4'b1111;
        store_data = cpu_wdata;
        case (cpu_op[1:0])
            2'b00: begin
                store_data = {4{cpu_wdata[7:0]}};
                store_be   = 4'b1000 >> off_aligned;
            end
            2'b01: begin
                store_data = {2{cpu_wdata[15:0]}};
                store_be   = off_aligned[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                store_data = cpu_wdata;
                store_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        lane_byte = mem_data_out[31:24];
        case (req_off)
            2'd0: lane_byte = mem_data_out[31:24];
            2'd1: lane_byte = mem_data_out[23:16];
            2'd2: lane_byte = mem_data_out[15:8];
            2'd3: lane_byte = mem_data_out[7:0];
            default: lane_byte = mem_data_out[31:24];
        endcase
        lane_half = req_off[1] ? mem_data_out[15:0] : mem_data_out[31:16];
        case (req_op)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'h0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'h0, lane_half};
            default: load_data = mem_data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cpu_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'h0;
            mem_address <= 32'h0;
            mem_read_en <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_byte_en <= 4'h0;
            mem_data_in <= 32'h0;
            req_store   <= 1'b0;
            req_op      <= 3'b000;
            req_off     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_valid && cpu_ready) begin
                        cpu_ready <= 1'b0;
                        req_store <= cpu_store;
                        req_op    <= cpu_op;
                        req_off   <= off_aligned;
                        if (illegal_op || misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state       <= ISSUE;
                            mem_address <= {cpu_addr[31:2], 2'b00};
                            if (cpu_store) begin
                                mem_wr_en   <= 1'b1;
                                mem_byte_en <= store_be;
                                mem_data_in <= store_data;
                            end else begin
                                mem_read_en <= 1'b1;
                                mem_byte_en <= 4'b1111;
                            end
                        end
                    end
                end
                ISSUE: begin
                    mem_read_en <= 1'b0;
                    mem_wr_en   <= 1'b0;
                    mem_byte_en <= 4'h0;
                    if (req_store) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    cpu_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a behavioural big-endian memory.
module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic        cpu_store = 1'b0;
    logic [2:0]  cpu_op = 3'b000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_wr_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    mips_load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_store(cpu_store),
        .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_wr_en(mem_wr_en),
        .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model plus strobe bookkeeping.
    logic [31:0] mem [0:127];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_raddr = 32'h0;
    logic [3:0]  last_wbe = 4'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge clk) begin
        if (mem_read_en) begin
            mem_data_out <= mem[mem_address[8:2]];
            rd_cnt       <= rd_cnt + 1;
            last_raddr   <= mem_address;
        end
        if (mem_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i]) mem[mem_address[8:2]][8*i +: 8] <= mem_data_in[8*i +: 8];
            wr_cnt     <= wr_cnt + 1;
            last_wbe   <= mem_byte_en;
            last_wdata <= mem_data_in;
        end
        if (mem_read_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    // Drives one request, scrambles the cpu_* fields after accept, and reports what came back.
    task automatic do_req(input logic st, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat, output int rd_n, output int wr_n,
                          output logic busy_ok, output logic ready_after);
        int rd0, wr0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_store = st; cpu_op = op; cpu_addr = addr; cpu_wdata = wd;
        for (int n = 0; n < 10 && !cpu_ready; n++) @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        cpu_valid = 1'b0; cpu_store = 1'b1; cpu_op = 3'b011; cpu_addr = 32'hFFFF_FFFC; cpu_wdata = 32'h0;
        lat = 0; busy_ok = 1'b1; rdata = 32'h0; err = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            if (cpu_ready) busy_ok = 1'b0;
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        @(negedge clk);
        ready_after = cpu_ready;
        rd_n = rd_cnt - rd0;
        wr_n = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({cpu_ready, resp_valid, resp_err, mem_read_en, mem_wr_en} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 10000", {cpu_ready, resp_valid, resp_err, mem_read_en, mem_wr_en});
        end
        vectors++;
        if ({mem_byte_en, mem_address, mem_data_in, resp_rdata} !== 100'h0) begin
            miscompares++;
            $display("FAIL reset_data: be=%h addr=%h din=%h rdata=%h expected all zero",
                     mem_byte_en, mem_address, mem_data_in, resp_rdata);
        end
        vectors++;
        if (dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
        logic [31:0] adrs [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFF_FF99, 32'h0000_00BB, 32'hFFFF_AABB, 32'h0000_8899, 32'h8899_AABB};
        logic [31:0] rd; logic er, busy, rdy; int lat, rn, wn;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, ops[i], adrs[i], 32'h0, rd, er, lat, rn, wn, busy, rdy);
            vectors++;
            if (rd !== exps[i] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL load_data[%0d]: got %h err=%b expected %h err=0", i, rd, er, exps[i]);
            end
            vectors++;
            if (lat != 3 || rn != 1 || wn != 0 || last_raddr !== 32'h100) begin
                miscompares++;
                $display("FAIL load_timing[%0d]: lat=%0d rd=%0d wr=%0d addr=%h expected 3/1/0/00000100",
                         i, lat, rn, wn, last_raddr);
            end
            vectors++;
            if (busy !== 1'b1 || rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL load_ready[%0d]: busy_ok=%b ready_after=%b expected 1/1", i, busy, rdy);
            end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er, busy, rdy; int lat, rn, wn;
        do_req(1'b1, 3'b000, 32'h102, 32'h1234_5678, rd, er, lat, rn, wn, busy, rdy);
        vectors++;
        if (lat != 2 || wn != 1 || rn != 0 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_resp: lat=%0d wr=%0d rd=%0d rdata=%h err=%b expected 2/1/0/0/0", lat, wn, rn, rd, er);
        end
        vectors++;
        if (last_wbe !== 4'b0010 || last_wdata !== 32'h7878_7878) begin
            miscompares++;
            $display("FAIL sb_lanes: be=%b data=%h expected 0010 78787878", last_wbe, last_wdata);
        end
        do_req(1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat, rn, wn, busy, rdy);
        vectors++;
        if (rd !== 32'h8899_78BB) begin
            miscompares++;
            $display("FAIL sb_readback: got %h expected 889978bb", rd);
        end
        do_req(1'b1, 3'b001, 32'h100, 32'h1234_5678, rd, er, lat, rn, wn, busy, rdy);
        vectors++;
        if (last_wbe !== 4'b1100 || last_wdata !== 32'h5678_5678 || lat != 2 || wn != 1) begin
            miscompares++;
            $display("FAIL sh_lanes: be=%b data=%h lat=%0d wr=%0d expected 1100 56785678 2 1", last_wbe, last_wdata, lat, wn);
        end
        do_req(1'b1, 3'b001, 32'h102, 32'h0000_CAFE, rd, er, lat, rn, wn, busy, rdy);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat, rn, wn, busy, rdy);
        vectors++;
        if (rd !== 32'h5678_CAFE) begin
            miscompares++;
            $display("FAIL sh_readback: got %h expected 5678cafe", rd);
        end
    endtask

    task automatic test_errors();
        logic        sts  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  ops  [4] = '{3'b011, 3'b001, 3'b111, 3'b100};
        logic [31:0] adrs [4] = '{32'h106, 32'h101, 32'h100, 32'h100};
        logic [31:0] rd; logic er, busy, rdy; int lat, rn, wn;
        for (int i = 0; i < 4; i++) begin
            do_req(sts[i], ops[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat, rn, wn, busy, rdy);
            vectors++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
                miscompares++;
                $display("FAIL err_resp[%0d]: err=%b rdata=%h lat=%0d expected 1/0/1", i, er, rd, lat);
            end
            vectors++;
            if (rn != 0 || wn != 0 || rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL err_nomem[%0d]: rd=%0d wr=%0d ready_after=%b expected 0/0/1", i, rn, wn, rdy);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic er, busy, rdy; int lat, rn, wn, rd0; logic saw;
        do_req(1'b1, 3'b011, 32'h100, 32'h8899_AABB, rd, er, lat, rn, wn, busy, rdy);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_store = 1'b0; cpu_op = 3'b011; cpu_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        cpu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (dbg_state !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_in_capture: state=%0d expected 2", dbg_state);
        end
        rd0 = rd_cnt;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cpu_ready, resp_valid, resp_err, mem_read_en, mem_wr_en} !== 5'b10000 ||
            mem_byte_en !== 4'h0 || mem_address !== 32'h0 || resp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_async: ctrl=%b be=%h addr=%h rdata=%h expected 10000/0/0/0",
                     {cpu_ready, resp_valid, resp_err, mem_read_en, mem_wr_en}, mem_byte_en, mem_address, resp_rdata);
        end
        saw = 1'b0;
        repeat (3) begin @(negedge clk); saw |= resp_valid; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); saw |= resp_valid; end
        vectors++;
        if (saw !== 1'b0 || cpu_ready !== 1'b1 || rd_cnt != rd0) begin
            miscompares++;
            $display("FAIL rst_dropped: resp_seen=%b ready=%b reads=%0d expected 0/1/0", saw, cpu_ready, rd_cnt - rd0);
        end
        do_req(1'b0, 3'b100, 32'h100, 32'h0, rd, er, lat, rn, wn, busy, rdy);
        vectors++;
        if (rd !== 32'h0000_0088 || lat != 3) begin
            miscompares++;
            $display("FAIL rst_then_lbu: got %h lat=%0d expected 00000088 3", rd, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd2; int lat1, lat2; logic busy;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_store = 1'b1; cpu_op = 3'b011; cpu_addr = 32'h104; cpu_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        cpu_store = 1'b0; cpu_wdata = 32'h0;
        lat1 = 0; lat2 = 0; busy = 1'b1; rd2 = 32'h0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            if (lat1 == 0 && resp_valid) lat1 = n;
            if (n == 4) cpu_valid = 1'b0;
            if (lat1 != 0 && n > lat1 + 1 && resp_valid && lat2 == 0) begin lat2 = n; rd2 = resp_rdata; end
            if (cpu_ready && n != lat1 + 1 && lat2 == 0) busy = 1'b0;
        end
        vectors++;
        if (lat1 != 2 || lat2 != 6) begin
            miscompares++;
            $display("FAIL b2b_timing: first resp cycle %0d second %0d expected 2 6", lat1, lat2);
        end
        vectors++;
        if (rd2 !== 32'hDEAD_BEEF || busy !== 1'b1 || both_cnt != 0) begin
            miscompares++;
            $display("FAIL b2b_data: got %h busy_ok=%b overlap=%0d expected deadbeef 1 0", rd2, busy, both_cnt);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        begin
            logic [31:0] rd; logic er, busy, rdy; int lat, rn, wn;
            do_req(1'b1, 3'b011, 32'h100, 32'h8899_AABB, rd, er, lat, rn, wn, busy, rdy);
        end
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
